// File: rtl/inst_fetch.sv
// Instruction fetch unit: issues word reads for the current PC over a req/ack
// handshake and buffers returned instructions with their PC for decode.
module inst_fetch #(
    parameter int unsigned DEPTH  = 2,
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] pc_in,
    output logic              pc_adv,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [DATA_W-1:0] inst,
    output logic [ADDR_W-1:0] inst_pc,
    input  logic              flush
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_REQ   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   fetch_pc_q, fetch_pc_d;
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic [DATA_W-1:0]   data_mem_q [DEPTH];
    logic [ADDR_W-1:0]   pc_mem_q   [DEPTH];
    logic                push;
    logic                pop;
    logic                fifo_full;

    assign fifo_full  = (count_q == CNT_W'(DEPTH));
    assign mem_req    = (state_q != S_IDLE);
    assign mem_addr   = {fetch_pc_q[ADDR_W-1:2], 2'b00};
    assign inst_valid = (count_q != '0);
    assign inst       = data_mem_q[rd_ptr_q];
    assign inst_pc    = pc_mem_q[rd_ptr_q];
    assign pop        = inst_valid & inst_ready & ~flush;
    assign pc_adv     = push;

    // Fetch sequencing: launch, wait for ack, or drain a flushed request.
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        push       = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!flush && !fifo_full) begin
                    state_d    = S_REQ;
                    fetch_pc_d = pc_in;
                end
            end
            S_REQ: begin
                if (mem_ack) begin
                    push    = ~flush;
                    state_d = S_IDLE;
                end else if (flush) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (mem_ack) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // FIFO pointer and occupancy update; flush empties the buffer.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // Control state registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            fetch_pc_q <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
        end
    end

    // FIFO storage; cleared on reset so the head reads zero while empty.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                data_mem_q[i] <= '0;
                pc_mem_q[i]   <= '0;
            end
        end else if (push) begin
            data_mem_q[wr_ptr_q] <= mem_rdata;
            pc_mem_q[wr_ptr_q]   <= fetch_pc_q;
        end
    end

endmodule

// File: doc/inst_fetch.md
Name: inst_fetch

Overview:
Instruction fetch unit at the consuming end of the program counter. It samples the current PC, issues a word read to instruction memory over a req/ack handshake, and buffers each returned instruction with its PC in a small FIFO for decode. It pulses an advance strobe back to the PC logic for every instruction it accepts. It supports a flush that discards buffered and in-flight instructions on redirect.

Parameters:
DEPTH, 2, output FIFO entries (power of two, >=2)
ADDR_W, 32, PC/address width
DATA_W, 32, instruction width

Ports:
clk  in  1  clock, all state updates on posedge
rst  in  1  synchronous reset, active-low (rst==0 resets on the clock edge)
pc_in  in  ADDR_W  current PC from program counter
pc_adv  out  1  one-cycle pulse: accepted instruction at pc_in, PC may advance
mem_req  out  1  memory read request
mem_addr  out  ADDR_W  read address, word aligned
mem_ack  in  1  memory response valid; completes the current request
mem_rdata  in  DATA_W  read data, valid when mem_ack=1
inst_valid  out  1  FIFO head valid
inst_ready  in  1  decode accepts head
inst  out  DATA_W  head instruction
inst_pc  out  ADDR_W  PC of head instruction
flush  in  1  discard buffered and in-flight fetches

Behaviour:
- Reset (rst==0 at posedge): state=IDLE; FIFO empty (count=0); mem_req=0; mem_addr=0; pc_adv=0; inst_valid=0; inst=0; inst_pc=0. Reset asserted mid-request abandons the request; a late mem_ack after reset is ignored in IDLE.
- Fetch address: fetch_pc registered from pc_in on entering REQ; mem_addr={fetch_pc[ADDR_W-1:2],2'b00}; held stable while mem_req=1.
- States:
  - IDLE: mem_req=0. If flush=0 and count<DEPTH -> REQ (latch fetch_pc). A flush cycle never launches a request.
  - REQ: mem_req=1. Wait for mem_ack.
    - On mem_ack with flush=0: push {fetch_pc, mem_rdata}, pc_adv=1 for that cycle, -> IDLE.
    - On mem_ack with flush=1: drop data, pc_adv=0, -> IDLE.
    - On flush=1 without mem_ack: -> DRAIN.
  - DRAIN: mem_req=1, same mem_addr; a request is never withdrawn before ack. On mem_ack: drop data, no pc_adv, -> IDLE. A further flush in DRAIN has no extra effect.
- Throughput: one instruction per 2 cycles minimum (REQ, IDLE); acks are taken no earlier than the cycle after mem_req rises.
- pc_adv is combinational from (state==REQ & mem_ack & ~flush); it is never asserted in IDLE or DRAIN.
- FIFO: registered; inst_valid=(count!=0); inst/inst_pc show the head entry. Pop when inst_valid & inst_ready. Push and pop in the same cycle leave count unchanged. REQ is entered only with count<DEPTH, and count cannot rise during REQ, so a push never overflows. Pointers wrap modulo DEPTH.
- Flush: count:=0 and pointers:=0 at the edge; inst_valid=0 the next cycle. A pop in the flush cycle is ignored, and no push occurs.
- Full: count==DEPTH holds IDLE with mem_req=0 until a pop.
- pc_in[1:0]!=0: the low bits are dropped on mem_addr; inst_pc records the unmodified fetch_pc.

Test Plan:
- Reset: hold rst=0 for 2 cycles, release, pc_in=0x0, inst_ready=1, mem_ack 1 cycle after req, rdata=0x00000013 -> cycle 1 mem_req=1 addr=0x0; ack cycle pc_adv=1; next cycle inst_valid=1 inst=0x13 inst_pc=0x0.
- Stream: PC model increments by 4 on pc_adv, memory returns addr^0xA5A50000 -> inst_pc sequence 0x0,0x4,0x8,0xC in order, no gaps or duplicates, one pc_adv per instruction.
- Backpressure: inst_ready=0, DEPTH=2 -> exactly 2 fetches, then mem_req stays 0. Raise inst_ready for 1 cycle -> one pop, one new request next cycle.
- Flush in-flight: flush for 1 cycle during REQ with ack 3 cycles later -> mem_req stays 1 with the same addr through DRAIN; ack produces no pc_adv and no push; inst_valid=0 after flush.
- Flush coincident with ack, and push+pop while count=1 -> no push, no pc_adv; count stays 1 with correct ordering.
- Reset mid-REQ: rst=0 while mem_req=1, then a stray mem_ack -> outputs return to reset values; FIFO stays empty.
